// File: rtl/dense_weight_sequencer.sv
// Walks a window of the weight ROM for a number of passes and streams the words
// out through a credit-managed FIFO with per-pass (last) and end-of-command (final) tags.
module dense_weight_sequencer #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 20,
  parameter int unsigned PASS_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [PASS_W-1:0] num_passes,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  output logic              w_final
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENT_W = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     words_q;
  logic [PASS_W-1:0]   passes_q;
  logic [ADDR_W:0]     idx;
  logic [PASS_W-1:0]   pass_cnt;

  // Read pipeline: issue_q = address presented, arrive_q = ROM data valid next edge
  logic                issue_q, issue_last, issue_final;
  logic                arrive_q, arrive_last, arrive_final;

  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_count;

  logic                push, pop, can_issue, is_last, is_final;
  logic [CNT_W:0]      occ;
  logic [CNT_W-1:0]    cnt_after_pop, count_nxt;
  logic [PTR_W-1:0]    rd_ptr_nxt;
  logic [ENT_W-1:0]    push_entry, head_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check, FIFO bookkeeping and the next registered head of the stream
  always_comb begin
    push          = arrive_q;
    pop           = w_valid && w_ready;
    push_entry    = {arrive_last, arrive_final, rom_data};
    occ           = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(issue_q) + (CNT_W+1)'(arrive_q);
    can_issue     = occ < (CNT_W+1)'(FIFO_DEPTH);
    is_last       = (idx == words_q - (ADDR_W+1)'(1));
    is_final      = is_last && (pass_cnt == passes_q - PASS_W'(1));
    cnt_after_pop = fifo_count - CNT_W'(pop);
    count_nxt     = cnt_after_pop + CNT_W'(push);
    rd_ptr_nxt    = pop ? ptr_inc(rd_ptr) : rd_ptr;
    head_nxt      = (cnt_after_pop == '0) ? push_entry : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      rom_addr     <= '0;
      base_q       <= '0;
      words_q      <= '0;
      passes_q     <= '0;
      idx          <= '0;
      pass_cnt     <= '0;
      issue_q      <= 1'b0;
      issue_last   <= 1'b0;
      issue_final  <= 1'b0;
      arrive_q     <= 1'b0;
      arrive_last  <= 1'b0;
      arrive_final <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      w_valid      <= 1'b0;
      w_data       <= '0;
      w_last       <= 1'b0;
      w_final      <= 1'b0;
    end else begin
      arrive_q     <= issue_q;
      arrive_last  <= issue_last;
      arrive_final <= issue_final;
      issue_q      <= 1'b0;
      fifo_count   <= count_nxt;
      rd_ptr       <= rd_ptr_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      w_valid                   <= (count_nxt != '0);
      {w_last, w_final, w_data} <= head_nxt;
      done         <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            words_q  <= num_words;
            passes_q <= num_passes;
            idx      <= '0;
            pass_cnt <= '0;
            busy     <= 1'b1;
            if (num_words == '0 || num_passes == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              rom_addr <= base_addr;
            end
          end
        end
        RUN: begin
          if (can_issue) begin
            rom_addr    <= base_q + idx[ADDR_W-1:0];
            issue_q     <= 1'b1;
            issue_last  <= is_last;
            issue_final <= is_final;
            if (is_last) begin
              idx      <= '0;
              pass_cnt <= pass_cnt + PASS_W'(1);
            end else begin
              idx <= idx + (ADDR_W+1)'(1);
            end
            if (is_final) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && w_final) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
